// File: rtl/toggle_stream_gen.sv
// Serialises a parallel word MSB first as a toggle-encoded stream on D and counts D=1 symbols.
// Optional return-to-zero trailer symbol enabled by defining TOGGLE_RETURN_ZERO_EN.
module toggle_stream_gen #(
  parameter int unsigned n = 64,
  parameter int unsigned h = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] par_in,
  output logic         D,
  output logic         busy,
  output logic         done,
  output logic [h-1:0] tcount
);

  localparam int unsigned IdxW = (n > 1) ? $clog2(n) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StRtz,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [n-1:0]    sr_q, sr_d;
  logic            prev_q, prev_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [h-1:0]    tcount_q, tcount_d;
  logic            d_q, d_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    prev_d   = prev_q;
    idx_d    = idx_q;
    tcount_d = tcount_q;
    d_d      = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          sr_d     = par_in;
          prev_d   = 1'b0;
          idx_d    = IdxW'(n - 1);
          tcount_d = '0;
          busy_d   = 1'b1;
          state_d  = StShift;
        end
      end

      StShift: begin
        // Symbol is the change from the previously sent data bit.
        d_d      = sr_q[n-1] ^ prev_q;
        prev_d   = sr_q[n-1];
        tcount_d = tcount_q + h'(d_d);
        sr_d     = sr_q << 1;
        idx_d    = idx_q - IdxW'(1);
        if (idx_q == '0) begin
`ifdef TOGGLE_RETURN_ZERO_EN
          state_d = StRtz;
`else
          state_d = StDone;
`endif
        end
      end

      StRtz: begin
        // Trailer toggles the receiver flop back to 0 if it was left at 1.
        d_d      = prev_q;
        tcount_d = tcount_q + h'(prev_q);
        prev_d   = 1'b0;
        state_d  = StDone;
      end

      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      sr_q     <= '0;
      prev_q   <= 1'b0;
      idx_q    <= '0;
      tcount_q <= '0;
      d_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      prev_q   <= prev_d;
      idx_q    <= idx_d;
      tcount_q <= tcount_d;
      d_q      <= d_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign D      = d_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign tcount = tcount_q;

endmodule

// File: tb/tb_toggle_stream_gen.sv
// Self-checking bench for toggle_stream_gen: table-driven frames with a symbol scoreboard.
module tb_toggle_stream_gen;

  localparam int unsigned N = 64;
  localparam int unsigned H = 8;
`ifdef TOGGLE_RETURN_ZERO_EN
  localparam int NSYM = N + 1;
`else
  localparam int NSYM = N;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] par_in = '0;
  logic         D;
  logic         busy;
  logic         done;
  logic [H-1:0] tcount;

  int checks = 0;
  int errors = 0;

  bit exp_q[$];

  typedef struct {
    logic [N-1:0] w;
    int           tc;
  } vec_t;

  vec_t vecs[5];

  toggle_stream_gen #(.n(N), .h(H)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .par_in(par_in),
    .D     (D),
    .busy  (busy),
    .done  (done),
    .tcount(tcount)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference encoder: pushes expected symbols, returns the number of ones.
  function automatic int push_model(input logic [N-1:0] w);
    bit prev = 1'b0;
    int ones = 0;
    for (int k = N - 1; k >= 0; k--) begin
      exp_q.push_back(w[k] ^ prev);
      ones += int'(w[k] ^ prev);
      prev = w[k];
    end
`ifdef TOGGLE_RETURN_ZERO_EN
    exp_q.push_back(prev);
    ones += int'(prev);
`endif
    return ones;
  endfunction

  // Runs one frame. restart_at/abort_at give the symbol edge for a spurious start or
  // a mid-frame reset (-1 = none). pre_started: start already driven in the prior done cycle.
  task automatic run_frame(input logic [N-1:0] w, input int exp_tc, input int restart_at,
                           input int abort_at, input bit pre_started, input bit chain,
                           input logic [N-1:0] next_w);
    int model_tc;
    bit tff = 1'b0;
    logic [N-1:0] rx = '0;
    if (!pre_started) begin
      @(negedge clock);
      start  = 1'b1;
      par_in = w;
    end
    model_tc = push_model(w);
    @(posedge clock);
    #1;
    start = 1'b0;
    check("busy_at_t0", 64'(busy), 64'd1);
    check("tcount_at_t0", 64'(tcount), 64'd0);
    for (int j = 1; j <= NSYM; j++) begin
      @(posedge clock);
      #1;
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 64'd1, 64'd0);
      end else begin
        check($sformatf("D_sym%0d", j), 64'(D), 64'(exp_q.pop_front()));
      end
      if (j == 1 || j == NSYM) check($sformatf("busy_sym%0d", j), 64'(busy), 64'd1);
      tff = tff ^ D;
      if (j <= N) rx = {rx[N-2:0], tff};
      if (j == restart_at - 1) begin
        start  = 1'b1;
        par_in = ~w;
      end
      if (j == restart_at) start = 1'b0;
      if (j == abort_at) begin
        #2 reset = 1'b1;
        #1;
        check("rst_D", 64'(D), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_tcount", 64'(tcount), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        return;
      end
    end
    @(posedge clock);
    #1;
    check("done_pulse", 64'(done), 64'd1);
    check("busy_low_at_done", 64'(busy), 64'd0);
    check("D_low_at_done", 64'(D), 64'd0);
    check("tcount_table", 64'(tcount), 64'(exp_tc));
    check("tcount_model", 64'(tcount), 64'(model_tc[H-1:0]));
    check("loopback", rx, w);
`ifdef TOGGLE_RETURN_ZERO_EN
    check("rtz_tff", 64'(tff), 64'd0);
`endif
    if (chain) begin
      start  = 1'b1;
      par_in = next_w;
    end else begin
      @(posedge clock);
      #1;
      check("done_one_cycle", 64'(done), 64'd0);
      check("tcount_hold", 64'(tcount), 64'(exp_tc));
    end
  endtask

  initial begin
    logic [N-1:0] rw;
    int rtc;

    vecs[0] = '{w: 64'h0000_0000_0000_0000, tc: 0};
    vecs[1] = '{w: 64'h8000_0000_0000_0000, tc: 2};
    vecs[2] = '{w: 64'hAAAA_AAAA_AAAA_AAAA, tc: 64};
`ifdef TOGGLE_RETURN_ZERO_EN
    vecs[3] = '{w: 64'hFFFF_FFFF_FFFF_FFFF, tc: 2};
    vecs[4] = '{w: 64'h5555_5555_5555_5555, tc: 64};
`else
    vecs[3] = '{w: 64'hFFFF_FFFF_FFFF_FFFF, tc: 1};
    vecs[4] = '{w: 64'h5555_5555_5555_5555, tc: 63};
`endif

    #12;
    check("reset_D", 64'(D), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_tcount", 64'(tcount), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("idle_D", 64'(D), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].w, vecs[i].tc, -1, -1, 1'b0, 1'b0, '0);
    end

    // Spurious start with changed data at t10 is ignored.
    run_frame(64'h8000_0000_0000_0000, 2, 10, -1, 1'b0, 1'b0, '0);

    // Start held in the done cycle is accepted at the following edge.
    run_frame(64'hFFFF_FFFF_FFFF_FFFF, vecs[3].tc, -1, -1, 1'b0, 1'b1,
              64'hAAAA_AAAA_AAAA_AAAA);
    run_frame(64'hAAAA_AAAA_AAAA_AAAA, 64, -1, -1, 1'b1, 1'b0, '0);

    // Asynchronous reset at t20, then a fresh frame starting from prev=0.
    run_frame(64'hFFFF_FFFF_FFFF_FFFF, 0, -1, 20, 1'b0, 1'b0, '0);
    run_frame(64'hFFFF_FFFF_FFFF_FFFF, vecs[3].tc, -1, -1, 1'b0, 1'b0, '0);

    rw = {$urandom(), $urandom()};
    rtc = push_model(rw);
    exp_q.delete();
    run_frame(rw, rtc, -1, -1, 1'b0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
